// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA display timing: pixel divider, scan counters, registered sync/position snapshot
module vga_timing_ctrl #(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_end,
  output logic       frame_start
);

  localparam int         DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SP       = (SYNC_POL != 0);

  logic [DW-1:0] div;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          tick_int;
  logic          h_end;
  logic          v_end;
  logic          hs_act;
  logic          vs_act;

  // >= rather than == so an out-of-range counter still wraps on the next tick
  always_comb begin
    tick_int = en && (div == DIV_LAST);
    h_end    = (h_cnt >= H_LAST);
    v_end    = (v_cnt >= V_LAST);
    hs_act   = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_act   = (v_cnt >= VS_START) && (v_cnt < VS_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pixel_tick  <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= ~SP;
      vsync       <= ~SP;
    end else begin
      pixel_tick  <= tick_int;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        div <= tick_int ? '0 : div + DW'(1);
      end
      if (tick_int) begin
        h_cnt <= h_end ? 10'd0 : h_cnt + 10'd1;
        if (h_end) begin
          v_cnt <= v_end ? 10'd0 : v_cnt + 10'd1;
        end
        // Snapshot of the pre-increment counters, so every output of one pixel lands together
        pixel_x     <= h_cnt;
        pixel_y     <= v_cnt;
        video_on    <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hsync       <= hs_act ? SP : ~SP;
        vsync       <= vs_act ? SP : ~SP;
        line_end    <= (h_cnt == H_LAST);
        frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - directed checks of vga_timing_ctrl at default and small parameters
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, rst_b, en_b;
  logic       a_tick, a_hs, a_vs, a_von, a_le, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_hs, b_vs, b_von, b_le, b_fs;
  logic [9:0] b_x, b_y;
  logic [31:0] obs_a, obs_b;

  int checks = 0;
  int errors = 0;

  vga_timing_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_a), .en(en_a), .pixel_tick(a_tick),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von),
    .pixel_x(a_x), .pixel_y(a_y), .line_end(a_le), .frame_start(a_fs)
  );

  vga_timing_ctrl #(
    .PIX_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_b), .en(en_b), .pixel_tick(b_tick),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
    .pixel_x(b_x), .pixel_y(b_y), .line_end(b_le), .frame_start(b_fs)
  );

  assign obs_a = {7'd0, a_hs, a_vs, a_von, a_x, a_y, a_le, a_fs};
  assign obs_b = {7'd0, b_hs, b_vs, b_von, b_x, b_y, b_le, b_fs};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Defaults: active-low syncs, hsync 656..751, vsync 490..491, 640x480 visible, 800 wide
  function automatic logic [31:0] exp_a(input int x, input int y);
    logic hs, vs, von, le, fs;
    hs  = !(x >= 656 && x < 752);
    vs  = !(y >= 490 && y < 492);
    von = (x < 640) && (y < 480);
    le  = (x == 799);
    fs  = (x == 0) && (y == 0);
    return {7'd0, hs, vs, von, 10'(x), 10'(y), le, fs};
  endfunction

  // Small: active-high syncs, hsync x=5..6, vsync y=2, visible 4x1, 8x4 total
  function automatic logic [31:0] exp_b(input int x, input int y);
    logic hs, vs, von, le, fs;
    hs  = (x >= 5 && x < 7);
    vs  = (y == 2);
    von = (x < 4) && (y < 1);
    le  = (x == 7);
    fs  = (x == 0) && (y == 0);
    return {7'd0, hs, vs, von, 10'(x), 10'(y), le, fs};
  endfunction

  task automatic step_a(input int ex, input int ey, input int exp_gap);
    int gap;
    bit seen;
    gap  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      gap++;
      seen = a_tick;
    end
    check("a_tick_seen", {31'd0, seen}, 32'd1);
    check("a_tick_gap", gap, exp_gap);
    check("a_pixel", obs_a, exp_a(ex, ey));
  endtask

  logic [31:0] rst_out_a;
  int          last_fs;

  initial begin
    rst_a = 1'b0; en_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0;
    rst_out_a = {7'd0, 2'b11, 23'd0};
    repeat (3) @(negedge clk);
    check("a_reset_tick", {31'd0, a_tick}, 32'd0);
    check("a_reset_out", obs_a, rst_out_a);
    check("b_reset_tick", {31'd0, b_tick}, 32'd0);
    check("b_reset_out", obs_b, 32'd0);

    // First line and into the second, every pixel two clocks apart
    rst_a = 1'b1; en_a = 1'b1;
    step_a(0, 0, 2);
    for (int p = 1; p <= 1100; p++) step_a(p % 800, p / 800, 2);

    // Pause at (300,1): everything holds, no ticks
    en_a = 1'b0;
    repeat (7) begin
      @(negedge clk);
      check("a_hold_tick", {31'd0, a_tick}, 32'd0);
      check("a_hold_out", obs_a, exp_a(300, 1));
    end
    en_a = 1'b1;
    for (int p = 1101; p <= 1300; p++) step_a(p % 800, p / 800, 2);

    // Asynchronous reset between edges at (500,1)
    #2 rst_a = 1'b0;
    #1;
    check("a_async_tick", {31'd0, a_tick}, 32'd0);
    check("a_async_out", obs_a, rst_out_a);
    @(negedge clk);
    rst_a = 1'b1;
    for (int p = 0; p < 4; p++) step_a(p, 0, 2);

    // Small instance: ticks every clock, two full frames plus a bit
    rst_b   = 1'b1; en_b = 1'b1;
    last_fs = -1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      check("b_tick", {31'd0, b_tick}, 32'd1);
      check("b_pixel", obs_b, exp_b(c % 8, (c / 8) % 4));
      if (b_fs) begin
        if (last_fs >= 0) check("b_frame_period", c - last_fs, 32);
        last_fs = c;
      end
    end
    check("b_frame_seen", last_fs, 64);
    en_b = 1'b0;
    @(negedge clk);
    check("b_en_off_tick", {31'd0, b_tick}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Display timing controller for the VGA output path. It derives a pixel-rate tick from the system clock and sequences the horizontal (0..H_TOTAL-1) and vertical (0..V_TOTAL-1) scan counters. The vertical counter advances only at end of line. From those counters it generates registered hsync, vsync, video-active and pixel coordinates for the pixel generator and the frame-level logic.

## Interface
Parameters:
- PIX_DIV, 2: system clocks per pixel tick (≥1)
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync pulse width, pixels
- H_BP, 48: horizontal back porch, pixels (H_TOTAL = sum = 800)
- V_ACTIVE, 480: visible lines
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vsync pulse width, lines
- V_BP, 33: vertical back porch, lines (V_TOTAL = sum = 525)
- SYNC_POL, 0: sync active level (0 = active-low)

Ports:
- clk  in  1  system clock; single clock domain, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  scan enable; low freezes divider and counters
- pixel_tick  out  1  one-clk pulse marking a new pixel slot (registered)
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high while the (x, y) snapshot is inside the active area
- pixel_x  out  10  horizontal position of current snapshot
- pixel_y  out  10  vertical position of current snapshot
- line_end  out  1  one-clk pulse, snapshot at x = H_TOTAL-1
- frame_start  out  1  one-clk pulse, snapshot at (0,0)

## Operation
- Divider: div counts 0..PIX_DIV-1 while en=1. tick_int = (div == PIX_DIV-1). div wraps to 0 on tick_int.
- h_cnt: increments on tick_int. At H_TOTAL-1 with tick_int, wraps to 0.
- v_cnt: increments only when tick_int and h_cnt = H_TOTAL-1. At V_TOTAL-1 under that condition, wraps to 0. Frame wrap (H_TOTAL-1, V_TOTAL-1) → (0,0) happens in a single step.
- Counters never exceed TOTAL-1. Any out-of-range value (not reachable normally) wraps to 0 on the next tick.
- Decode is taken from the (h_cnt, v_cnt) pair and registered on the clk edge where tick_int=1:
  - hsync = SYNC_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC; else ~SYNC_POL. Defaults: active for 656..751.
  - vsync: same rule using the V parameters. Defaults: active for lines 490..491.
  - video_on = (h < H_ACTIVE) && (v < V_ACTIVE).
  - pixel_x = h, pixel_y = v. Both update on every tick, including blanking.
  - line_end = (h = H_TOTAL-1). frame_start = (h = 0 && v = 0). Each is high for exactly the one clk of its registered tick.
- pixel_tick is a registered copy of tick_int. Outputs change only in the clk where pixel_tick=1.
- en=0: div, h_cnt, v_cnt and all registered outputs hold their values. pixel_tick, line_end and frame_start are forced to 0. On re-enable, counting resumes from the held div value with no skipped or duplicated pixel.

## Timing
- Reset (async assert, any time, including mid-frame): div=0, h_cnt=0, v_cnt=0, pixel_tick=0, line_end=0, frame_start=0, video_on=0, pixel_x=0, pixel_y=0, hsync=vsync=~SYNC_POL.
- Release is synchronous in effect: the first tick_int occurs PIX_DIV clks after the first edge with rst_n=1 and en=1.
- Latency: outputs are a registered snapshot of the counter state, 1 clk after the edge where that state was current. All outputs of a given pixel (sync, video_on, x, y, pulses) appear in the same clk.
- PIX_DIV=1: tick_int is permanently high while en=1, so pixel_tick stays high.
- Frame period: H_TOTAL·V_TOTAL·PIX_DIV clks. Defaults: 840 000 clks.

## Test plan
- Reset, then en=1 with defaults: pixel_tick pulses every 2 clks. First snapshot is pixel_x=0, pixel_y=0, video_on=1, frame_start=1, hsync=vsync=1.
- Run one line: snapshots x=0..799. video_on falls at x=640. hsync is 0 exactly for x=656..751. line_end=1 only at x=799. The next snapshot is x=0, y=1.
- Run a full frame: vsync is 0 exactly for y=490..491. video_on=0 for all y≥480. After (799,524) the next snapshot is (0,0) with frame_start=1. frame_start recurs every 840 000 clks.
- Drop en for 7 clks mid-line at x=300: outputs hold, pixel_tick=0. After re-enable the next snapshot is x=301 and tick spacing is preserved.
- Assert rst_n=0 asynchronously at (500,200) between clk edges: all outputs reach reset values immediately. After release, the sequence restarts at (0,0).
- PIX_DIV=1, H_TOTAL=8, V_TOTAL=4 (small parameters): pixel_tick is constantly high. Frame wraps every 32 clks. Wrap (7,3)→(0,0) occurs with no extra cycle.
